// File: rtl/fpu_pkg.sv
// Shared types for the FP add/sub issue stage: request record, op encodings and dispatch states.
package fpu_pkg;

  localparam int DATA_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic              op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } fpu_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } disp_state_e;

endpackage

// File: rtl/op_fifo.sv
// Synchronous request FIFO of fpu_req_t; push/pop are ignored when full/empty.
module op_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  fpu_req_t               wdata,
  output fpu_req_t               rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  fpu_req_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: state updates use <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fpu_op_dispatcher.sv
// Issue stage for the FP add/sub unit: queues requests, issues one at a time with a start
// pulse, captures the result on ready and flags a hung unit through a sticky watchdog timeout.
module fpu_op_dispatcher
  import fpu_pkg::*;
#(
  parameter int DATA_W  = fpu_pkg::DATA_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_op,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  output logic                   fpu_start,
  output logic                   fpu_op,
  output logic [DATA_W-1:0]      fpu_a,
  output logic [DATA_W-1:0]      fpu_b,
  input  logic                   fpu_busy,
  input  logic                   fpu_ready,
  input  logic [DATA_W-1:0]      fpu_data,
  output logic                   res_valid,
  output logic [DATA_W-1:0]      res_data,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   timeout
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  disp_state_e       state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  fpu_req_t          req_q, req_d, head, in_req;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d;
  logic              timeout_q, timeout_d;
  logic              pop, full, empty;

  assign in_req = '{op: in_op, a: in_a, b: in_b};

  op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_req),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  // NOTE: every variable written below gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    req_d       = req_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    timeout_d   = timeout_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !fpu_busy) begin
          pop     = 1'b1;
          req_d   = head;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion is signalled by ready alone; busy is not consulted once issued.
        if (fpu_ready) begin
          res_data_d  = fpu_data;
          res_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      req_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      req_q       <= req_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign in_ready  = !full;
  assign fpu_start = (state_q == ISSUE);
  assign fpu_op    = req_q.op;
  assign fpu_a     = req_q.a;
  assign fpu_b     = req_q.b;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign timeout   = timeout_q;

endmodule
